branch_pc_ctrl: RTL and testbench

BRANCH_PC_CTRL -- requirements
Module: branch_pc_ctrl

---
 rtl/branch_pc_ctrl.sv | 118 +++++++++++
 tb/tb_branch_pc_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: branch resolution and PC sequencing for a single-issue core.
//
// Resolves conditional branches, JAL and JALR against the comparator flags,
// steps the PC, and diverts to a TRAP state when a redirect lands on a
// misaligned (non word-aligned) target. Keeps saturating counters of retired
// and taken conditional branches.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   en                     advance enable (0 = stall, hold all state)
//   is_branch/jal/jalr     instruction class (priority jalr > jal > branch)
//   funct3, imm, rs1       branch condition code, immediate, JALR base
//   BrEq, BrLt             comparator flags
//   trap_ack               trap handler acknowledge (only honoured in TRAP)
//   BrUn                   unsigned-compare select to the comparator (comb)
//   pc, pc_plus4           current PC (registered) and its link value
//   taken, illegal_br      combinational redirect / illegal-condition flags
//   trap, mtval            registered trap status and faulting target
//   br_cnt, tk_cnt         saturating retired / taken branch counters
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        BrEq,
  input  logic        BrLt,
  input  logic        trap_ack,
  output logic        BrUn,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        illegal_br,
  output logic        trap,
  output logic [31:0] mtval,
  output logic [15:0] br_cnt,
  output logic [15:0] tk_cnt
);

  typedef enum logic {RUN, TRAP} state_t;

  state_t      state;
  logic        selJalr, selJal, selBr;
  logic        condTrue;
  logic [31:0] jalrSum;
  logic [31:0] target;
  logic        misaligned;

  // Instruction select: a higher-priority class masks the lower ones.
  assign selJalr = is_jalr;
  assign selJal  = ~is_jalr & is_jal;
  assign selBr   = ~is_jalr & ~is_jal & is_branch;

  assign BrUn       = funct3[1];
  assign illegal_br = is_branch & (funct3[2:1] == 2'b01);

  always_comb begin
    condTrue = 1'b0;
    case (funct3)
      3'b000:         condTrue = BrEq;
      3'b001:         condTrue = ~BrEq;
      3'b100, 3'b110: condTrue = BrLt;
      3'b101, 3'b111: condTrue = ~BrLt;
      default:        condTrue = 1'b0;   // 010/011: illegal, never taken
    endcase
  end

  assign jalrSum    = rs1 + imm;
  assign target     = selJalr ? {jalrSum[31:1], 1'b0} : pc + imm;
  assign taken      = selJalr | selJal | (selBr & condTrue);
  assign misaligned = target[1:0] != 2'b00;
  assign pc_plus4   = pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC;
      trap   <= 1'b0;
      mtval  <= '0;
      br_cnt <= '0;
      tk_cnt <= '0;
    end else if (en) begin
      case (state)
        RUN: begin
          // A trapping branch still retires, so counting precedes the
          // misalignment decision.
          if (selBr && br_cnt != 16'hFFFF) br_cnt <= br_cnt + 16'd1;
          if (selBr && condTrue && tk_cnt != 16'hFFFF) tk_cnt <= tk_cnt + 16'd1;
          if (taken && misaligned) begin
            mtval <= target;
            trap  <= 1'b1;
            state <= TRAP;
          end else if (taken) begin
            pc <= target;
          end else begin
            pc <= pc_plus4;
          end
        end
        TRAP: begin
          if (trap_ack) begin
            pc    <= TRAP_VEC;
            trap  <= 1'b0;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_ctrl.sv
module tb_branch_pc_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, is_branch, is_jal, is_jalr, BrEq, BrLt, trap_ack;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1;
  logic        BrUn, taken, illegal_br, trap;
  logic [31:0] pc, pc_plus4, mtval;
  logic [15:0] br_cnt, tk_cnt;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [31:0] mPc, mMtval;
  int          mBr, mTk;
  bit          mTrap;

  always #5 clk = ~clk;

  branch_pc_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .en(en), .is_branch(is_branch), .is_jal(is_jal),
    .is_jalr(is_jalr), .funct3(funct3), .imm(imm), .rs1(rs1), .BrEq(BrEq),
    .BrLt(BrLt), .trap_ack(trap_ack), .BrUn(BrUn), .pc(pc), .pc_plus4(pc_plus4),
    .taken(taken), .illegal_br(illegal_br), .trap(trap), .mtval(mtval),
    .br_cnt(br_cnt), .tk_cnt(tk_cnt)
  );

  // ---------------- reference model ----------------
  // Condition: 01x never; otherwise compare flag (bit2 picks lt/eq), bit0 inverts.
  function automatic bit expCond(input logic [2:0] f, input logic eq, input logic lt);
    logic [2:0] g;
    g = f;
    if (g == 3'd2 || g == 3'd3) return 1'b0;
    return (g >= 3'd4 ? lt : eq) ^ g[0];
  endfunction

  function automatic bit expTaken();
    if (is_jalr || is_jal) return 1'b1;
    if (is_branch) return expCond(funct3, BrEq, BrLt);
    return 1'b0;
  endfunction

  function automatic logic [31:0] expTarget();
    logic [31:0] s;
    if (is_jalr) begin
      s = rs1 + imm;
      return s - (s % 2);
    end
    return mPc + imm;
  endfunction

  function automatic void modelStep();
    logic [31:0] t;
    if (!en) return;
    if (mTrap) begin
      if (trap_ack) begin mPc = TRAP_VEC; mTrap = 0; end
      return;
    end
    if (is_branch && !is_jal && !is_jalr) begin
      if (mBr < 65535) mBr++;
      if (expCond(funct3, BrEq, BrLt) && mTk < 65535) mTk++;
    end
    t = expTarget();
    if (expTaken() && (t % 4) != 0) begin mMtval = t; mTrap = 1; end
    else if (expTaken()) mPc = t;
    else mPc = mPc + 4;
  endfunction

  task automatic idle();
    is_branch = 0; is_jal = 0; is_jalr = 0; funct3 = 3'b000;
    imm = 0; rs1 = 0; BrEq = 0; BrLt = 0; trap_ack = 0; en = 1;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk); #1;
  endtask

  // Steer pc to a value with a single JAL.
  task automatic goPc(input logic [31:0] dst);
    idle(); is_jal = 1; imm = dst - mPc;
    tick();
    idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(); en = 0; rst = 1;
    mPc = RESET_PC; mMtval = 0; mBr = 0; mTk = 0; mTrap = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    checks++; if (trap !== 1'b0 || mtval !== 32'h0) begin errors++; $display("FAIL reset_trap: got trap=%b mtval=%h want 0/0", trap, mtval); end
    checks++; if (br_cnt !== 16'h0 || tk_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", br_cnt, tk_cnt); end
    rst = 0; en = 1;
    tick();  // first enabled edge advances from RESET_PC
    checks++; if (pc !== RESET_PC + 4) begin errors++; $display("FAIL first_advance: got %h want %h", pc, RESET_PC + 4); end
  endtask

  task automatic test_branch_eq();
    goPc(32'h100);
    is_branch = 1; funct3 = 3'b000; BrEq = 1; imm = 32'h20; #1;
    checks++; if (taken !== 1'b1 || BrUn !== 1'b0) begin errors++; $display("FAIL beq_comb: got taken=%b BrUn=%b want 1/0", taken, BrUn); end
    tick();
    checks++; if (pc !== 32'h120) begin errors++; $display("FAIL beq_pc: got %h want 120", pc); end
    checks++; if (br_cnt !== 16'(mBr) || tk_cnt !== 16'(mTk) || mBr != 1 || mTk != 1) begin errors++; $display("FAIL beq_cnt: got %0d/%0d want 1/1", br_cnt, tk_cnt); end
    idle();
  endtask

  task automatic test_branch_lt_not_taken();
    goPc(32'h100);
    is_branch = 1; funct3 = 3'b110; BrLt = 0; imm = 32'h40; #1;
    checks++; if (BrUn !== 1'b1 || taken !== 1'b0) begin errors++; $display("FAIL bltu_comb: got BrUn=%b taken=%b want 1/0", BrUn, taken); end
    tick();
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL bltu_pc: got %h want 104", pc); end
    checks++; if (br_cnt !== 16'(mBr) || tk_cnt !== 16'(mTk)) begin errors++; $display("FAIL bltu_cnt: got %0d/%0d want %0d/%0d", br_cnt, tk_cnt, mBr, mTk); end
    // illegal condition codes: flagged, never taken, still counted
    is_branch = 1; funct3 = 3'b011; BrEq = 1; BrLt = 1; #1;
    checks++; if (illegal_br !== 1'b1 || taken !== 1'b0) begin errors++; $display("FAIL illegal_comb: got ill=%b taken=%b want 1/0", illegal_br, taken); end
    tick();
    checks++; if (br_cnt !== 16'(mBr) || pc !== mPc) begin errors++; $display("FAIL illegal_cnt: got cnt=%0d pc=%h want %0d/%h", br_cnt, pc, mBr, mPc); end
    idle();
  endtask

  task automatic test_jalr_trap();
    int br0;
    logic [31:0] pc0;
    pc0 = mPc;
    is_jalr = 1; is_jal = 1; is_branch = 1; funct3 = 3'b000; BrEq = 1;
    rs1 = 32'h2001; imm = 32'h1; #1;
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL jalr_taken: got %b want 1", taken); end
    br0 = mBr;
    tick();
    checks++; if (trap !== 1'b1 || mtval !== 32'h2002 || pc !== pc0) begin errors++; $display("FAIL jalr_trap: got trap=%b mtval=%h pc=%h want 1/2002/%h", trap, mtval, pc, pc0); end
    checks++; if (br_cnt !== 16'(br0)) begin errors++; $display("FAIL jalr_nocount: got %0d want %0d", br_cnt, br0); end
    // in TRAP: instructions ignored, stalled ack ignored
    idle(); is_branch = 1; funct3 = 3'b000; BrEq = 1; imm = 32'h8;
    tick();
    idle(); en = 0; trap_ack = 1;
    tick();
    checks++; if (trap !== 1'b1 || pc !== pc0 || br_cnt !== 16'(br0)) begin errors++; $display("FAIL trap_hold: got trap=%b pc=%h br=%0d want 1/%h/%0d", trap, pc, br_cnt, pc0, br0); end
    en = 1;
    tick();
    checks++; if (trap !== 1'b0 || pc !== TRAP_VEC) begin errors++; $display("FAIL trap_ack: got trap=%b pc=%h want 0/%h", trap, pc, TRAP_VEC); end
    // trap_ack in RUN ignored
    tick();
    checks++; if (pc !== TRAP_VEC + 4) begin errors++; $display("FAIL ack_in_run: got %h want %h", pc, TRAP_VEC + 4); end
    idle();
  endtask

  task automatic test_misaligned_branch();
    int br0, tk0;
    br0 = mBr; tk0 = mTk;
    is_branch = 1; funct3 = 3'b101; BrLt = 0; imm = 32'h6;
    tick();
    checks++; if (trap !== 1'b1 || mtval !== mMtval || br_cnt !== 16'(br0 + 1) || tk_cnt !== 16'(tk0 + 1)) begin
      errors++; $display("FAIL br_trap: got trap=%b mtval=%h cnt=%0d/%0d want 1/%h/%0d/%0d", trap, mtval, br_cnt, tk_cnt, mMtval, br0 + 1, tk0 + 1); end
    idle(); trap_ack = 1;
    tick();
    idle();
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    pc0 = pc;
    idle(); en = 0; is_jal = 1; imm = 32'h40;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (taken !== 1'b1) begin errors++; $display("FAIL stall_taken: got %b want 1", taken); end
      tick();
      checks++; if (pc !== pc0 || br_cnt !== 16'(mBr) || tk_cnt !== 16'(mTk)) begin errors++; $display("FAIL stall_hold: got pc=%h cnt=%0d/%0d want %h/%0d/%0d", pc, br_cnt, tk_cnt, pc0, mBr, mTk); end
    end
    idle();
  endtask

  task automatic test_pc_wrap();
    idle(); is_jalr = 1; rs1 = 32'hFFFF_FFFC; imm = 0;
    tick();
    idle(); #1;
    checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL pc_wrap: got pc=%h p4=%h want fffffffc/0", pc, pc_plus4); end
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap_step: got %h want 0", pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      idle();
      en        = ($urandom_range(0, 9) != 0);
      is_branch = $urandom_range(0, 1);
      is_jal    = ($urandom_range(0, 5) == 0);
      is_jalr   = ($urandom_range(0, 5) == 0);
      funct3    = 3'($urandom_range(0, 7));
      BrEq      = $urandom_range(0, 1);
      BrLt      = $urandom_range(0, 1);
      trap_ack  = $urandom_range(0, 1);
      rs1       = $urandom;
      imm       = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 63)) - 32
                                              : (32'($urandom_range(0, 255)) - 128) * 4;
      #1;
      checks++; if (taken !== expTaken() || BrUn !== funct3[1] || illegal_br !== (is_branch && (funct3 == 3'd2 || funct3 == 3'd3))) begin
        errors++; $display("FAIL rnd_comb[%0d]: got t=%b u=%b i=%b want t=%b", i, taken, BrUn, illegal_br, expTaken()); end
      checks++; if (pc_plus4 !== mPc + 4) begin errors++; $display("FAIL rnd_p4[%0d]: got %h want %h", i, pc_plus4, mPc + 4); end
      tick();
      checks++; if (pc !== mPc || trap !== mTrap || mtval !== mMtval || br_cnt !== 16'(mBr) || tk_cnt !== 16'(mTk)) begin
        errors++; $display("FAIL rnd_state[%0d]: got pc=%h tr=%b mt=%h c=%0d/%0d want %h/%b/%h/%0d/%0d",
                           i, pc, trap, mtval, br_cnt, tk_cnt, mPc, mTrap, mMtval, mBr, mTk); end
    end
    idle();
    if (mTrap) begin trap_ack = 1; tick(); idle(); end
  endtask

  task automatic test_saturation();
    int tk0;
    idle(); rst = 1; #2; rst = 0;
    mPc = RESET_PC; mMtval = 0; mBr = 0; mTk = 0; mTrap = 0;
    is_branch = 1; funct3 = 3'b010;  // illegal code: counted, never taken
    for (int i = 0; i < 65535; i++) tick();
    checks++; if (br_cnt !== 16'hFFFF || pc !== mPc) begin errors++; $display("FAIL sat_preload: got %h pc=%h want ffff/%h", br_cnt, pc, mPc); end
    tk0 = mTk;
    funct3 = 3'b000; BrEq = 1; imm = 32'h8;
    tick();
    checks++; if (br_cnt !== 16'hFFFF || tk_cnt !== 16'(tk0 + 1)) begin errors++; $display("FAIL sat_taken: got %h/%h want ffff/%h", br_cnt, tk_cnt, 16'(tk0 + 1)); end
    idle();
  endtask

  task automatic test_async_reset_in_trap();
    idle(); is_jal = 1; imm = 32'h2;
    tick();
    idle();
    checks++; if (trap !== 1'b1) begin errors++; $display("FAIL pre_reset_trap: got %b want 1", trap); end
    #3 rst = 1;  // mid-cycle, away from any edge
    #1;
    checks++; if (pc !== RESET_PC || trap !== 1'b0 || br_cnt !== 16'h0 || tk_cnt !== 16'h0 || mtval !== 32'h0) begin
      errors++; $display("FAIL async_reset: got pc=%h trap=%b cnt=%h/%h mtval=%h want %h/0/0/0/0", pc, trap, br_cnt, tk_cnt, mtval, RESET_PC); end
    @(posedge clk); #1 rst = 0;
    mPc = RESET_PC; mMtval = 0; mBr = 0; mTk = 0; mTrap = 0;
    tick();
    checks++; if (pc !== RESET_PC + 4 || trap !== 1'b0) begin errors++; $display("FAIL post_reset_run: got pc=%h trap=%b want %h/0", pc, trap, RESET_PC + 4); end
  endtask

  initial begin
    test_reset();
    test_branch_eq();
    test_branch_lt_not_taken();
    test_jalr_trap();
    test_misaligned_branch();
    test_stall();
    test_pc_wrap();
    test_random();
    test_saturation();
    test_async_reset_in_trap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
